sort_stream_pipe: RTL and testbench

//  Parametrised, fully pipelined odd-even transposition sorter for NUM values of DATA_WIDTH bits.

---
 rtl/sort_pkg.sv | 13 +
 rtl/sort_cmp_stage.sv | 63 ++++++
 rtl/sort_stream_pipe.sv | 76 +++++++
 tb/tb_sort_stream_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared helpers for the streaming odd-even transposition sorter.
// Index math for element slices and the median tap.
package sort_pkg;

    function automatic int med_idx(input int num);
        return (num - 1) / 2;
    endfunction

    function automatic int elem_lsb(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/sort_cmp_stage.sv
// One registered compare-exchange layer of the odd-even transposition network.
// PARITY=1 pairs (i,i+1) with i even; PARITY=0 pairs them with i odd.
module sort_cmp_stage
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM        = 7,
    parameter int PARITY     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      en,
    input  logic                      in_valid,
    input  logic                      in_desc,
    input  logic [NUM*DATA_WIDTH-1:0] in_data,
    output logic                      out_valid,
    output logic                      out_desc,
    output logic [NUM*DATA_WIDTH-1:0] out_data
);

    localparam int LO = 1 - PARITY;

    logic [NUM*DATA_WIDTH-1:0] data_d, data_q;
    logic                      valid_q, desc_q;

    for (genvar i = 0; i < NUM; i++) begin : g_el
        localparam int P = ((i % 2) == LO) ? i : i - 1;
        localparam int L = elem_lsb(i, DATA_WIDTH);
        if (P >= 0 && P + 1 < NUM) begin : g_pair
            logic [DATA_WIDTH-1:0] a, b;
            logic                  swap;
            assign a = in_data[elem_lsb(P, DATA_WIDTH) +: DATA_WIDTH];
            assign b = in_data[elem_lsb(P + 1, DATA_WIDTH) +: DATA_WIDTH];
            // Strict compares so equal keys never move
            assign swap = in_desc ? (a < b) : (a > b);
            if (i == P) begin : g_lo
                assign data_d[L +: DATA_WIDTH] = swap ? b : a;
            end else begin : g_hi
                assign data_d[L +: DATA_WIDTH] = swap ? a : b;
            end
        end else begin : g_pass
            assign data_d[L +: DATA_WIDTH] = in_data[L +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid_q <= 1'b0;
            desc_q  <= 1'b0;
            data_q  <= '0;
        end else if (en) begin
            valid_q <= in_valid;
            desc_q  <= in_desc;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_desc  = desc_q;
    assign out_data  = data_q;

endmodule

// File: rtl/sort_stream_pipe.sv
// Fully pipelined odd-even transposition sorter with valid/ready flow
// control, per-sample sort direction and a median tap.
module sort_stream_pipe
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM        = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      refresh,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM*DATA_WIDTH-1:0] in_data,
    input  logic                      in_desc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM*DATA_WIDTH-1:0] out_data,
    output logic [DATA_WIDTH-1:0]     out_median,
    output logic                      out_desc
);

    localparam int VW  = NUM * DATA_WIDTH;
    localparam int MED = med_idx(NUM);

    logic          en;
    logic          valid_q, desc_q;
    logic [VW-1:0] data_q;
    logic [NUM:0]  v_s, d_s;
    logic [VW-1:0] dat_s [NUM+1];

    // Global stall: every stage freezes while the output is held
    assign en       = out_ready | ~out_valid;
    assign in_ready = en & ~rst & ~refresh;

    always_ff @(posedge clk) begin
        if (rst || refresh) begin
            valid_q <= 1'b0;
            desc_q  <= 1'b0;
            data_q  <= '0;
        end else if (en) begin
            valid_q <= in_valid;
            desc_q  <= in_desc;
            data_q  <= in_data;
        end
    end

    assign v_s[0]   = valid_q;
    assign d_s[0]   = desc_q;
    assign dat_s[0] = data_q;

    for (genvar k = 1; k <= NUM; k++) begin : g_stage
        sort_cmp_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM        (NUM),
            .PARITY     (k % 2)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .clr       (refresh),
            .en        (en),
            .in_valid  (v_s[k-1]),
            .in_desc   (d_s[k-1]),
            .in_data   (dat_s[k-1]),
            .out_valid (v_s[k]),
            .out_desc  (d_s[k]),
            .out_data  (dat_s[k])
        );
    end

    assign out_valid  = v_s[NUM];
    assign out_desc   = d_s[NUM];
    assign out_data   = dat_s[NUM];
    assign out_median = dat_s[NUM][elem_lsb(MED, DATA_WIDTH) +: DATA_WIDTH];

endmodule

// File: tb/tb_sort_stream_pipe.sv
// Directed bench for sort_stream_pipe with a scoreboard on the output port.
module tb_sort_stream_pipe;

    localparam int DW = 8;
    localparam int N  = 7;
    localparam int VW = N * DW;

    typedef struct packed {
        logic [VW-1:0] data;
        logic          desc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, refresh, in_valid, in_ready, in_desc;
    logic          out_valid, out_ready, out_desc;
    logic [VW-1:0] in_data, out_data;
    logic [DW-1:0] out_median;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sort_stream_pipe #(.DATA_WIDTH(DW), .NUM(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .refresh    (refresh),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_desc    (in_desc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_median (out_median),
        .out_desc   (out_desc)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] vec7(input int e0, e1, e2, e3,
                                           input int e4, e5, e6);
        logic [VW-1:0] v;
        v = {e6[7:0], e5[7:0], e4[7:0], e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
        return v;
    endfunction

    function automatic logic [VW-1:0] ref_sort(input logic [VW-1:0] d,
                                               input logic desc);
        logic [DW-1:0] a [N];
        logic [DW-1:0] t;
        logic [VW-1:0] r;
        for (int i = 0; i < N; i++) a[i] = d[i*DW +: DW];
        for (int i = 1; i < N; i++)
            for (int j = i; j > 0; j--)
                if (desc ? (a[j] > a[j-1]) : (a[j] < a[j-1])) begin
                    t = a[j]; a[j] = a[j-1]; a[j-1] = t;
                end
        for (int i = 0; i < N; i++) r[i*DW +: DW] = a[i];
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_extra", 1, 0);
            else begin
                e = sb.pop_front();
                chk("sb_data", out_data, e.data);
                chk("sb_med", out_median, e.data[3*DW +: DW]);
                chk("sb_desc", out_desc, e.desc);
            end
        end
        if (rst || refresh) sb.delete();
        else if (in_valid && in_ready)
            sb.push_back(exp_t'{ref_sort(in_data, in_desc), in_desc});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string tag, input logic [VW-1:0] d,
                            input logic ds, input logic [VW-1:0] ed,
                            input logic [DW-1:0] em);
        int n;
        in_valid = 1'b1; in_data = d; in_desc = ds;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin tick(); n++; end
        chk({tag, "_lat"}, n, 8);
        chk({tag, "_data"}, out_data, ed);
        chk({tag, "_med"}, out_median, em);
        chk({tag, "_desc"}, out_desc, ds);
        tick();
    endtask

    initial begin
        logic [63:0]   r;
        logic [VW-1:0] v4 [10];
        logic [VW-1:0] frozen;
        int            first, last, cnt, sent, nv, n;
        bit            exp_rdy;

        rst = 1'b1; refresh = 1'b0; in_valid = 1'b0; in_desc = 1'b0;
        in_data = '0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_med", out_median, 0);
        chk("rst_desc", out_desc, 0);
        chk("rst_rdy", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", in_ready, 1);
        tick();

        send_one("asc", vec7(9, 3, 7, 1, 8, 2, 5), 1'b0,
                 vec7(1, 2, 3, 5, 7, 8, 9), 8'd5);
        send_one("dsc", vec7(0, 255, 0, 255, 128, 128, 1), 1'b1,
                 vec7(255, 255, 128, 128, 1, 0, 0), 8'd128);

        // Back-to-back, alternating direction
        first = -1; last = -1; cnt = 0;
        for (int c = 0; c < 40; c++) begin
            in_valid = (c < 20);
            r = {$urandom(), $urandom()};
            in_data = r[VW-1:0];
            in_desc = c[0];
            #1;
            if (out_valid) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
            tick();
        end
        chk("b2b_cnt", cnt, 20);
        chk("b2b_first", first, 8);
        chk("b2b_last", last, 27);

        // Backpressure window
        for (int i = 0; i < 10; i++) begin
            r = {$urandom(), $urandom()};
            v4[i] = r[VW-1:0];
        end
        sent = 0; last = -1; frozen = '0;
        for (int c = 0; c < 26; c++) begin
            exp_rdy = !(c >= 9 && c <= 12);
            out_ready = exp_rdy;
            in_valid = (sent < 10);
            in_data = v4[sent < 10 ? sent : 9];
            in_desc = sent[0];
            #1;
            chk($sformatf("bp_rdy%0d", c), in_ready, exp_rdy);
            if (out_valid) last = c;
            if (c == 9) frozen = out_data;
            if (c >= 10 && c <= 12) chk($sformatf("bp_frz%0d", c), out_data, frozen);
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_last", last, 21);
        chk("bp_sent", sent, 10);

        // Refresh with three vectors in flight
        nv = 0;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 3);
            r = {$urandom(), $urandom()};
            in_data = r[VW-1:0];
            in_desc = 1'b0;
            refresh = (c == 4);
            #1;
            if (c == 4) chk("rf_rdy", in_ready, 0);
            if (c == 5) begin
                chk("rf_data", out_data, 0);
                chk("rf_rdy1", in_ready, 1);
            end
            if (out_valid) nv++;
            tick();
        end
        chk("rf_novalid", nv, 0);
        send_one("rf_new", vec7(4, 4, 1, 0, 9, 9, 2), 1'b0,
                 vec7(0, 1, 2, 4, 4, 9, 9), 8'd4);

        // Reset colliding with in_valid and a held output
        in_valid = 1'b1; in_data = vec7(5, 1, 4, 2, 3, 7, 6); in_desc = 1'b0;
        tick();
        in_data = vec7(10, 20, 30, 40, 50, 60, 70); in_desc = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 2;
        while (!out_valid && n < 20) begin tick(); n++; end
        chk("rs_lat", n, 8);
        tick();
        chk("rs_bvalid", out_valid, 1);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        in_data = vec7(1, 2, 3, 4, 5, 6, 7);
        #1;
        chk("rs_rdy", in_ready, 0);
        tick();
        chk("rs_valid", out_valid, 0);
        chk("rs_data", out_data, 0);
        chk("rs_med", out_median, 0);
        chk("rs_desc", out_desc, 0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        nv = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) nv++;
            tick();
        end
        chk("rs_dropped", nv, 0);
        chk("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
